core_op_sequencer: RTL

Programmable test sequencer that drives the L1 cache core-side port through the core stimulus pass-through stage. It holds a small op table (loads, stores, AMOs, LR/SC), issues ops one at a time with a req/gnt handshake, waits for the single rvalid of each op, and checks returned data against expected values. It reports busy/done status, an error count and a timeout flag to the system testbench.

---
 rtl/core_op_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_op_sequencer.sv
// core_op_sequencer: programmable op table that replays loads, stores, AMOs
// and LR/SC through a req/gnt + rvalid port, one op outstanding at a time,
// counting data mismatches and spurious responses and aborting on timeout.
module core_op_sequencer #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we_i,
    input  logic [IW-1:0]     prog_idx_i,
    input  logic [2:0]        prog_kind_i,
    input  logic [7:0]        prog_be_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_wdata_i,
    input  logic [4:0]        prog_amo_op_i,
    input  logic              prog_amo_word_i,
    input  logic              prog_chk_i,
    input  logic [DATA_W-1:0] prog_exp_i,
    input  logic              start_i,
    input  logic [IW:0]       num_ops_i,
    output logic              seq_req_o,
    output logic              seq_we_o,
    output logic [7:0]        seq_be_o,
    output logic [ADDR_W-1:0] seq_addr_o,
    output logic [DATA_W-1:0] seq_wdata_o,
    output logic              seq_amo_o,
    output logic              seq_lr_o,
    output logic              seq_sc_o,
    output logic [4:0]        seq_amo_op_o,
    output logic              seq_amo_word_o,
    input  logic              seq_gnt_i,
    input  logic              seq_rvalid_i,
    input  logic [DATA_W-1:0] seq_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [15:0]       err_cnt_o,
    output logic [DATA_W-1:0] last_rdata_o
);
    // Handshake: seq_req_o is held with stable fields until seq_gnt_i is
    // sampled high on a rising edge; each granted op then owes exactly one
    // seq_rvalid_i pulse, and the next request is only raised after it.
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] K_STORE = 3'd1;
    localparam logic [2:0] K_AMO   = 3'd2;
    localparam logic [2:0] K_LR    = 3'd3;
    localparam logic [2:0] K_SC    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_R = 2'd2,
        S_FIN    = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]        kind;
        logic [7:0]        be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [4:0]        amo_op;
        logic              amo_word;
        logic              chk;
        logic [DATA_W-1:0] exp;
    } op_t;

    op_t               table_q [DEPTH];
    op_t               cur_op;
    state_e            state_q, state_d;
    logic [IW:0]       ptr_q, ptr_d;
    logic [IW:0]       num_q, num_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [15:0]       err_q, err_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              busy;
    logic              start_ok;
    logic              last_op;
    logic              tmo_fire;

    assign cur_op   = table_q[ptr_q[IW-1:0]];
    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_R);
    assign start_ok = start_i && !busy;
    assign last_op  = (ptr_q + (IW+1)'(1)) == num_q;
    // An arriving grant or response wins over a timeout in the same cycle.
    assign tmo_fire = (tcnt_q >= TW'(TIMEOUT - 1)) &&
                      (((state_q == S_ISSUE) && !seq_gnt_i) ||
                       ((state_q == S_WAIT_R) && !seq_rvalid_i));

    // Op table: writable only when no run is in progress, never reset.
    always_ff @(posedge clk) begin
        if (prog_we_i && !busy) begin
            table_q[prog_idx_i] <= '{kind: prog_kind_i, be: prog_be_i, addr: prog_addr_i,
                                     wdata: prog_wdata_i, amo_op: prog_amo_op_i,
                                     amo_word: prog_amo_word_i, chk: prog_chk_i,
                                     exp: prog_exp_i};
        end
    end

    // State and run-status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            num_q   <= '0;
            tcnt_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            num_q   <= num_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
        end
    end

    // Next-state: walk ISSUE/WAIT_R per op, FIN lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start_ok) state_d = (num_ops_i == '0) ? S_FIN : S_ISSUE;
                else          state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (seq_gnt_i)     state_d = S_WAIT_R;
                else if (tmo_fire) state_d = S_FIN;
            end
            S_WAIT_R: begin
                if (seq_rvalid_i)  state_d = last_op ? S_FIN : S_ISSUE;
                else if (tmo_fire) state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Run bookkeeping: pointer, per-op timer, error count and sticky flags.
    always_comb begin
        logic err_inc;
        ptr_d   = ptr_q;
        num_d   = num_q;
        tcnt_d  = tcnt_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        last_d  = last_q;
        err_inc = 1'b0;
        if (start_ok) begin
            num_d  = num_ops_i;
            ptr_d  = '0;
            done_d = 1'b0;
            tmo_d  = 1'b0;
        end
        if (seq_rvalid_i) begin
            if (state_q == S_WAIT_R) begin
                last_d = seq_rdata_i;
                ptr_d  = ptr_q + (IW+1)'(1);
                if (cur_op.chk && (seq_rdata_i != cur_op.exp)) err_inc = 1'b1;
            end else begin
                err_inc = 1'b1;
            end
        end
        if (tmo_fire) tmo_d = 1'b1;
        if (state_d == S_FIN) done_d = 1'b1;
        if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) tcnt_d = '0;
        else if (busy && (tcnt_q != TW'(TIMEOUT))) tcnt_d = tcnt_q + TW'(1);
        if (start_ok)                        err_d = '0;
        else if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        else                                 err_d = err_q;
    end

    // Request outputs: decoded from the registered state and pointer only.
    always_comb begin
        seq_req_o      = 1'b0;
        seq_we_o       = 1'b0;
        seq_be_o       = '0;
        seq_addr_o     = '0;
        seq_wdata_o    = '0;
        seq_amo_o      = 1'b0;
        seq_lr_o       = 1'b0;
        seq_sc_o       = 1'b0;
        seq_amo_op_o   = '0;
        seq_amo_word_o = 1'b0;
        if (state_q == S_ISSUE) begin
            seq_req_o  = 1'b1;
            seq_be_o   = cur_op.be;
            seq_addr_o = cur_op.addr;
            case (cur_op.kind)
                K_STORE: begin
                    seq_we_o    = 1'b1;
                    seq_wdata_o = cur_op.wdata;
                end
                K_AMO: begin
                    seq_amo_o      = 1'b1;
                    seq_wdata_o    = cur_op.wdata;
                    seq_amo_op_o   = cur_op.amo_op;
                    seq_amo_word_o = cur_op.amo_word;
                end
                K_LR: seq_lr_o = 1'b1;
                K_SC: begin
                    seq_sc_o    = 1'b1;
                    seq_wdata_o = cur_op.wdata;
                end
                default: ;
            endcase
        end
    end

    assign busy_o       = busy;
    assign done_o       = done_q;
    assign timeout_o    = tmo_q;
    assign err_cnt_o    = err_q;
    assign last_rdata_o = last_q;

endmodule
